pi_txn_queue: RTL and testbench

- Posted-transaction queue between the Pi GPIO register interface and the 68K bus cycle sequencer.
- Synchronises Pi write strobes into the c7m domain and assembles address, data and control from register writes.
- Queues complete bus operations so the Pi can post several writes back-to-back without waiting for each 68K bus cycle.
- Reads act as barriers: the Pi stays stalled until the read data returns.

---
 rtl/pistormx_pkg.sv | 20 ++
 rtl/pi_strobe_sync.sv | 33 +++
 rtl/pi_txn_queue.sv | 193 +++++++++++++++++++
 tb/tb_pi_txn_queue.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pistormx_pkg.sv
// Shared Pi interface definitions: register selects and the queued 68K bus operation.
package pistormx_pkg;

  localparam logic [1:0] REG_DATA    = 2'd0;
  localparam logic [1:0] REG_ADDR_LO = 2'd1;
  localparam logic [1:0] REG_ADDR_HI = 2'd2;
  localparam logic [1:0] REG_STATUS  = 2'd3;

  typedef struct packed {
    logic [23:1] a;
    logic [15:0] d;
    logic        a0;
    logic        sz;
    logic        rw;
  } bus_op_t;

  // Idle/cleared entry: a read with zero address and data.
  localparam bus_op_t BUS_OP_RESET = '{a: 23'd0, d: 16'd0, a0: 1'b0, sz: 1'b0, rw: 1'b1};

endpackage

// File: rtl/pi_strobe_sync.sv
// Two-flop synchroniser for an asynchronous Pi strobe plus a rising-edge detector.
module pi_strobe_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  input  logic d_i,
  output logic pulse_o_c
);

  logic sync1_q;
  logic sync2_q;
  logic prev_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
    end else if (clr_i) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
    end else begin
      sync1_q <= d_i;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  // One-cycle pulse on the first synchronised high sample.
  assign pulse_o_c = sync2_q & ~prev_q;

endmodule

// File: rtl/pi_txn_queue.sv
// Posted-transaction queue between the Pi register interface and the 68K bus sequencer.
// Reads act as barriers: nothing further is issued until their data returns.
module pi_txn_queue
  import pistormx_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic        c7m,
  input  logic        reset_n,
  input  logic        pi_wr,
  input  logic [1:0]  pi_a,
  input  logic [15:0] pi_d,
  input  logic        flush,
  output logic        pi_busy,
  output logic [15:0] rd_data,
  output logic        overflow,
  output logic        op_valid,
  output logic [23:1] op_a,
  output logic [15:0] op_d,
  output logic        op_a0,
  output logic        op_sz,
  output logic        op_rw,
  input  logic        op_ack,
  input  logic        op_done,
  input  logic [15:0] op_rdata
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic wr_pulse;

  logic [23:1] stage_a_q,  stage_a_d;
  logic [15:0] stage_d_q,  stage_d_d;
  logic        stage_a0_q, stage_a0_d;
  logic        stage_sz_q, stage_sz_d;
  logic        stage_rw_q, stage_rw_d;

  bus_op_t     mem_q [DEPTH];
  bus_op_t     mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q,  count_d;
  logic [CNT_W-1:0] rdq_cnt_q, rdq_cnt_d;

  logic        read_pending_q, read_pending_d;
  logic        overflow_q,     overflow_d;
  logic [15:0] rd_data_q,      rd_data_d;
  logic        busy_q,         busy_d;

  logic        push_req;
  logic        push;
  logic        pop;
  logic        full;
  bus_op_t     new_op;
  bus_op_t     head;

  pi_strobe_sync u_wr_sync (
    .clk       (c7m),
    .rst_n     (reset_n),
    .clr_i     (flush),
    .d_i       (pi_wr),
    .pulse_o_c (wr_pulse)
  );

  assign head     = mem_q[rd_ptr_q];
  assign op_valid = (count_q != '0) && !read_pending_q;
  assign full     = (count_q == CNT_W'(DEPTH));
  assign push_req = wr_pulse && (pi_a == REG_ADDR_HI);
  assign push     = push_req && !full;
  assign pop      = op_ack && op_valid;

  always_comb begin
    stage_a_d      = stage_a_q;
    stage_d_d      = stage_d_q;
    stage_a0_d     = stage_a0_q;
    stage_sz_d     = stage_sz_q;
    stage_rw_d     = stage_rw_q;
    mem_d          = mem_q;
    wr_ptr_d       = wr_ptr_q;
    rd_ptr_d       = rd_ptr_q;
    count_d        = count_q;
    rdq_cnt_d      = rdq_cnt_q;
    read_pending_d = read_pending_q;
    overflow_d     = overflow_q;
    rd_data_d      = rd_data_q;
    busy_d         = 1'b0;

    // Register decode; ADDR_HI fields feed the push in the same cycle.
    if (wr_pulse) begin
      case (pi_a)
        REG_DATA: stage_d_d = pi_d;
        REG_ADDR_LO: begin
          stage_a_d[15:1] = pi_d[15:1];
          stage_a0_d      = pi_d[0];
        end
        REG_ADDR_HI: begin
          stage_a_d[23:16] = pi_d[7:0];
          stage_sz_d       = pi_d[8];
          stage_rw_d       = pi_d[9];
        end
        default: ;
      endcase
    end

    new_op = '{a: stage_a_d, d: stage_d_d, a0: stage_a0_d, sz: stage_sz_d, rw: stage_rw_d};

    if (push) begin
      mem_d[wr_ptr_q] = new_op;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (push_req && full) begin
      overflow_d = 1'b1;
    end

    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
      if (head.rw) begin
        read_pending_d = 1'b1;
      end
    end

    count_d   = count_q + CNT_W'(push) - CNT_W'(pop);
    rdq_cnt_d = rdq_cnt_q + CNT_W'(push && new_op.rw) - CNT_W'(pop && head.rw);

    if (op_done && read_pending_q) begin
      rd_data_d      = op_rdata;
      read_pending_d = 1'b0;
    end

    // Hold the Pi while it must wait: full queue or a read outstanding anywhere.
    busy_d = push_req || (count_d == CNT_W'(DEPTH)) || read_pending_d || (rdq_cnt_d != '0);

    if (flush) begin
      stage_a_d      = '0;
      stage_d_d      = '0;
      stage_a0_d     = 1'b0;
      stage_sz_d     = 1'b0;
      stage_rw_d     = 1'b1;
      mem_d          = '{default: BUS_OP_RESET};
      wr_ptr_d       = '0;
      rd_ptr_d       = '0;
      count_d        = '0;
      rdq_cnt_d      = '0;
      read_pending_d = 1'b0;
      busy_d         = 1'b0;
    end
  end

  always_ff @(posedge c7m or negedge reset_n) begin
    if (!reset_n) begin
      stage_a_q      <= '0;
      stage_d_q      <= '0;
      stage_a0_q     <= 1'b0;
      stage_sz_q     <= 1'b0;
      stage_rw_q     <= 1'b1;
      mem_q          <= '{default: BUS_OP_RESET};
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      count_q        <= '0;
      rdq_cnt_q      <= '0;
      read_pending_q <= 1'b0;
      overflow_q     <= 1'b0;
      rd_data_q      <= '0;
      busy_q         <= 1'b0;
    end else begin
      stage_a_q      <= stage_a_d;
      stage_d_q      <= stage_d_d;
      stage_a0_q     <= stage_a0_d;
      stage_sz_q     <= stage_sz_d;
      stage_rw_q     <= stage_rw_d;
      mem_q          <= mem_d;
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      count_q        <= count_d;
      rdq_cnt_q      <= rdq_cnt_d;
      read_pending_q <= read_pending_d;
      overflow_q     <= overflow_d;
      rd_data_q      <= rd_data_d;
      busy_q         <= busy_d;
    end
  end

  assign pi_busy  = busy_q;
  assign overflow = overflow_q;
  assign rd_data  = rd_data_q;
  assign op_a     = head.a;
  assign op_d     = head.d;
  assign op_a0    = head.a0;
  assign op_sz    = head.sz;
  assign op_rw    = head.rw;

endmodule

// File: tb/tb_pi_txn_queue.sv
// Directed bench for pi_txn_queue with a scoreboard of expected head entries.
module tb_pi_txn_queue;
  import pistormx_pkg::*;

  localparam int unsigned DEPTH = 4;

  logic        c7m = 1'b0;
  logic        reset_n;
  logic        pi_wr;
  logic [1:0]  pi_a;
  logic [15:0] pi_d;
  logic        flush;
  logic        pi_busy;
  logic [15:0] rd_data;
  logic        overflow;
  logic        op_valid;
  logic [23:1] op_a;
  logic [15:0] op_d;
  logic        op_a0;
  logic        op_sz;
  logic        op_rw;
  logic        op_ack;
  logic        op_done;
  logic [15:0] op_rdata;

  int      n_pass  = 0;
  int      n_total = 0;
  bus_op_t sb[$];
  logic    busy_p;
  logic    busy_n;

  pi_txn_queue #(.DEPTH(DEPTH)) dut (
    .c7m      (c7m),
    .reset_n  (reset_n),
    .pi_wr    (pi_wr),
    .pi_a     (pi_a),
    .pi_d     (pi_d),
    .flush    (flush),
    .pi_busy  (pi_busy),
    .rd_data  (rd_data),
    .overflow (overflow),
    .op_valid (op_valid),
    .op_a     (op_a),
    .op_d     (op_d),
    .op_a0    (op_a0),
    .op_sz    (op_sz),
    .op_rw    (op_rw),
    .op_ack   (op_ack),
    .op_done  (op_done),
    .op_rdata (op_rdata)
  );

  always #5 c7m = ~c7m;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total = n_total + 1;
    assert (obs === exp) n_pass = n_pass + 1;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Compare the presented head with the oldest expected entry and retire it.
  task automatic check_head(input string tag);
    bus_op_t e;
    e = sb.pop_front();
    chk({tag, "_valid"}, 64'(op_valid), 64'd1);
    chk(tag, 64'({op_a, op_d, op_a0, op_sz, op_rw}), 64'(e));
  endtask

  task automatic ack_head(input string tag);
    check_head(tag);
    op_ack = 1'b1;
    @(negedge c7m);
    op_ack = 1'b0;
  endtask

  // One Pi register write; entered and left on a falling edge.
  task automatic pi_write(input logic [1:0] a, input logic [15:0] d, input bit ack);
    pi_a  = a;
    pi_d  = d;
    pi_wr = 1'b1;
    repeat (2) @(negedge c7m);
    if (ack) begin
      check_head("ack_at_push");
      op_ack = 1'b1;
    end
    @(negedge c7m);
    op_ack = 1'b0;
    busy_p = pi_busy;
    pi_wr  = 1'b0;
    @(negedge c7m);
    busy_n = pi_busy;
    repeat (2) @(negedge c7m);
  endtask

  task automatic post(input logic [23:0] addr, input logic [15:0] data,
                      input logic sz, input logic rw, input bit ack);
    bus_op_t e;
    e.a  = addr[23:1];
    e.d  = data;
    e.a0 = addr[0];
    e.sz = sz;
    e.rw = rw;
    pi_write(REG_ADDR_LO, addr[15:0], 1'b0);
    pi_write(REG_DATA, data, 1'b0);
    pi_write(REG_ADDR_HI, {6'd0, rw, sz, addr[23:16]}, ack);
    if (sb.size() < DEPTH) sb.push_back(e);
  endtask

  task automatic pulse_done(input logic [15:0] rdata);
    op_done  = 1'b1;
    op_rdata = rdata;
    @(negedge c7m);
    op_done  = 1'b0;
    op_rdata = 16'h0000;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_busy"}, 64'(pi_busy), 64'd0);
    chk({tag, "_valid"}, 64'(op_valid), 64'd0);
    chk({tag, "_ovf"}, 64'(overflow), 64'd0);
    chk({tag, "_rd_data"}, 64'(rd_data), 64'd0);
    chk({tag, "_op"}, 64'({op_a, op_d, op_a0, op_sz, op_rw}), 64'd1);
  endtask

  initial begin
    reset_n  = 1'b0;
    pi_wr    = 1'b0;
    pi_a     = 2'd0;
    pi_d     = 16'h0000;
    flush    = 1'b0;
    op_ack   = 1'b0;
    op_done  = 1'b0;
    op_rdata = 16'h0000;
    busy_p   = 1'b0;
    busy_n   = 1'b0;

    #23;
    check_reset_outputs("reset");
    @(negedge c7m);
    reset_n = 1'b1;
    @(negedge c7m);

    // Single posted write.
    post(24'hFC1234, 16'hBEEF, 1'b0, 1'b0, 1'b0);
    chk("post_busy_pulse", 64'(busy_p), 64'd1);
    chk("post_busy_drop", 64'(busy_n), 64'd0);
    chk("post_op_a", 64'(op_a), 64'h7E091A);
    chk("post_op_d", 64'(op_d), 64'hBEEF);
    chk("post_op_rw", 64'(op_rw), 64'd0);
    ack_head("post_head");
    chk("post_empty", 64'(op_valid), 64'd0);

    // Fill past capacity with no acks.
    for (int i = 0; i < 5; i++) begin
      post(24'h020000 + 24'(i * 24'h0112) + 24'(i % 2), 16'h1100 + 16'(i), 1'(i % 2), 1'b0, 1'b0);
      if (i < 3) chk("fill_busy_low", 64'(busy_n), 64'd0);
      else       chk("fill_busy_high", 64'(busy_n), 64'd1);
      if (i < 4) chk("fill_no_ovf", 64'(overflow), 64'd0);
      else       chk("fill_ovf", 64'(overflow), 64'd1);
    end
    for (int i = 0; i < 4; i++) ack_head("fill_order");
    chk("fill_drained", 64'(op_valid), 64'd0);
    chk("fill_busy_released", 64'(pi_busy), 64'd0);
    chk("fill_ovf_sticky", 64'(overflow), 64'd1);

    // Read barrier.
    post(24'h00A000, 16'h0A0A, 1'b0, 1'b0, 1'b0);
    post(24'h00B002, 16'h0B0B, 1'b0, 1'b1, 1'b0);
    chk("rb_busy_read_queued", 64'(busy_n), 64'd1);
    post(24'h00C004, 16'h0C0C, 1'b1, 1'b0, 1'b0);
    chk("rb_busy_held", 64'(busy_n), 64'd1);
    ack_head("rb_head_a");
    pulse_done(16'h1234);
    chk("rb_write_done_no_rd", 64'(rd_data), 64'd0);
    ack_head("rb_head_b");
    repeat (2) @(negedge c7m);
    chk("rb_blocked_valid", 64'(op_valid), 64'd0);
    chk("rb_blocked_busy", 64'(pi_busy), 64'd1);
    op_ack = 1'b1;
    @(negedge c7m);
    op_ack = 1'b0;
    chk("rb_stray_ack", 64'(op_valid), 64'd0);
    pulse_done(16'h5A5A);
    chk("rb_rd_data", 64'(rd_data), 64'h5A5A);
    chk("rb_busy_fall", 64'(pi_busy), 64'd0);
    ack_head("rb_head_c");
    chk("rb_empty", 64'(op_valid), 64'd0);

    // Push and pop in the same cycle at count 2, across pointer wrap.
    post(24'h100000, 16'hA000, 1'b0, 1'b0, 1'b0);
    post(24'h102468, 16'hA001, 1'b1, 1'b0, 1'b0);
    for (int i = 2; i < 7; i++) begin
      post(24'h100000 + 24'(i * 24'h2468) + 24'(i % 2), 16'hA000 ^ 16'(i), 1'(i % 2), 1'b0, 1'b1);
      chk("simul_busy_drop", 64'(busy_n), 64'd0);
      chk("simul_head", 64'({op_a, op_d, op_a0, op_sz, op_rw}), 64'(sb[0]));
    end
    ack_head("simul_drain");
    ack_head("simul_drain");
    chk("simul_count2_empty", 64'(op_valid), 64'd0);

    // Flush with entries queued and a read outstanding.
    post(24'h200000, 16'h2222, 1'b0, 1'b1, 1'b0);
    post(24'h200010, 16'h3333, 1'b0, 1'b0, 1'b0);
    post(24'h200020, 16'h4444, 1'b0, 1'b0, 1'b0);
    post(24'h200030, 16'h5555, 1'b0, 1'b0, 1'b0);
    ack_head("flush_read_head");
    flush = 1'b1;
    @(negedge c7m);
    flush = 1'b0;
    sb.delete();
    chk("flush_valid", 64'(op_valid), 64'd0);
    chk("flush_busy", 64'(pi_busy), 64'd0);
    chk("flush_ovf_kept", 64'(overflow), 64'd1);
    chk("flush_rd_kept", 64'(rd_data), 64'h5A5A);
    post(24'h300100, 16'h6666, 1'b0, 1'b0, 1'b0);
    chk("flush_after_busy", 64'(busy_n), 64'd0);
    ack_head("flush_after_head");

    // Asynchronous reset with entries queued.
    post(24'h400200, 16'h7777, 1'b0, 1'b0, 1'b0);
    post(24'h400300, 16'h8888, 1'b0, 1'b0, 1'b0);
    #2;
    reset_n = 1'b0;
    #1;
    check_reset_outputs("async_rst");
    sb.delete();
    @(negedge c7m);
    reset_n = 1'b1;
    @(negedge c7m);
    post(24'h500402, 16'h9999, 1'b1, 1'b0, 1'b0);
    chk("rst_first_busy_pulse", 64'(busy_p), 64'd1);
    chk("rst_first_busy_drop", 64'(busy_n), 64'd0);
    ack_head("rst_first_head");
    chk("rst_first_empty", 64'(op_valid), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
